// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the fetch/memory stages, the arbiter and the shared backing memory.
interface unified_mem_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_done;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  d_req;
    logic                  d_we;
    logic                  d_byte;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_done;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  mem_req;
    logic                  mem_we;
    logic                  mem_byte;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  stall_if;
    logic                  stall_mem;
    logic                  err;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_ready, mem_rdata,
        output i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_byte, mem_addr,
        output mem_wdata, stall_if, stall_mem, err
    );

    // Core/memory side
    modport master (
        output i_req, i_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_ready, mem_rdata,
        input  i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_byte, mem_addr,
        input  mem_wdata, stall_if, stall_mem, err
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access:
// data-first priority, bounded fetch starvation, req/ready sequencing with timeout.
module unified_mem_arbiter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned MAX_DGRANTS = 4,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    unified_mem_arbiter_if.slave  bus
);
    localparam int unsigned DCNT_W = $clog2(MAX_DGRANTS + 1);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    state_t                state_next;
    logic                  owner_d;
    logic [DCNT_W-1:0]     dcnt;
    logic [TCNT_W-1:0]     tcnt;
    logic                  grant_d_c;
    logic                  grant_i_c;
    logic                  ready_c;
    logic                  timeout_c;
    logic                  finish_c;
    logic [ADDR_WIDTH-1:0] grant_addr_c;
    logic [DATA_WIDTH-1:0] grant_wdata_c;
    logic [DATA_WIDTH-1:0] rdata_c;

    assign bus.stall_if  = bus.i_req & ~bus.i_done;
    assign bus.stall_mem = bus.d_req & ~bus.d_done;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Arbitration, handshake completion and timeout decisions
    always_comb begin
        state_next = state;
        grant_d_c  = 1'b0;
        grant_i_c  = 1'b0;
        ready_c    = 1'b0;
        timeout_c  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.d_req && !(bus.i_req && dcnt == DCNT_W'(MAX_DGRANTS))) begin
                    grant_d_c  = 1'b1;
                    state_next = WAIT;
                end else if (bus.i_req) begin
                    grant_i_c  = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_ready) begin
                    ready_c    = 1'b1;
                    state_next = RESP;
                end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                    timeout_c  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        finish_c      = ready_c | timeout_c;
        grant_addr_c  = grant_d_c ? bus.d_addr : bus.i_addr;
        grant_wdata_c = grant_d_c ? bus.d_wdata : '0;
        rdata_c       = ready_c ? bus.mem_rdata : '0;
    end

    // Latched request, memory-side outputs and per-owner responses
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_d       <= 1'b0;
            dcnt          <= '0;
            tcnt          <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_byte  <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.i_done    <= 1'b0;
            bus.d_done    <= 1'b0;
            bus.i_rdata   <= '0;
            bus.d_rdata   <= '0;
            bus.err       <= 1'b0;
        end else begin
            bus.i_done <= 1'b0;
            bus.d_done <= 1'b0;
            if (grant_d_c || grant_i_c) begin
                owner_d       <= grant_d_c;
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= grant_d_c & bus.d_we;
                bus.mem_byte  <= grant_d_c & bus.d_byte;
                bus.mem_addr  <= grant_addr_c;
                bus.mem_wdata <= grant_wdata_c;
            end
            if (finish_c) begin
                bus.mem_req  <= 1'b0;
                bus.mem_we   <= 1'b0;
                bus.mem_byte <= 1'b0;
                if (owner_d) begin
                    bus.d_done <= 1'b1;
                    if (!bus.mem_we) bus.d_rdata <= rdata_c;
                end else begin
                    bus.i_done  <= 1'b1;
                    bus.i_rdata <= rdata_c;
                end
            end
            if (timeout_c) bus.err <= 1'b1;

            if (state == WAIT && !finish_c) tcnt <= tcnt + TCNT_W'(1);
            else                            tcnt <= '0;

            // Streak of data grants while fetch is waiting
            if (!bus.i_req || grant_i_c)                          dcnt <= '0;
            else if (grant_d_c && dcnt != DCNT_W'(MAX_DGRANTS))   dcnt <= dcnt + DCNT_W'(1);
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized scoreboard bench for unified_mem_arbiter with a transaction-level memory/arbitration model.
module tb_unified_mem_arbiter;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 32;
    localparam int unsigned MAXD = 4;
    localparam int unsigned TMO  = 64;

    typedef struct packed {
        logic        we;
        logic        bsel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dop_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    unified_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_DGRANTS(MAXD), .TIMEOUT(TMO))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    // Environment memory (written by the DUT) and reference memory (written by the model)
    logic [7:0] mem_b [512];
    logic [7:0] ref_b [512];

    function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic bsel);
        int i;
        if (bsel) return {24'h0, mem_b[int'(a[8:0])]};
        i = int'(a[8:2]) * 4;
        return {mem_b[i+3], mem_b[i+2], mem_b[i+1], mem_b[i]};
    endfunction

    task automatic mem_wr(input logic [31:0] a, input logic bsel, input logic [31:0] v);
        int i;
        if (bsel) mem_b[int'(a[8:0])] = v[7:0];
        else begin
            i = int'(a[8:2]) * 4;
            {mem_b[i+3], mem_b[i+2], mem_b[i+1], mem_b[i]} = v;
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a, input logic bsel);
        int i;
        if (bsel) return {24'h0, ref_b[int'(a[8:0])]};
        i = int'(a[8:2]) * 4;
        return {ref_b[i+3], ref_b[i+2], ref_b[i+1], ref_b[i]};
    endfunction

    task automatic ref_wr(input logic [31:0] a, input logic bsel, input logic [31:0] v);
        int i;
        if (bsel) ref_b[int'(a[8:0])] = v[7:0];
        else begin
            i = int'(a[8:2]) * 4;
            {ref_b[i+3], ref_b[i+2], ref_b[i+1], ref_b[i]} = v;
        end
    endtask

    // Memory responder: random latency, optional hang
    bit hang = 1'b0;
    int lat_lo = 0;
    int lat_hi = 0;
    bit serving = 1'b0;
    int lat_cnt = 0;

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                bus.mem_ready = 1'b0;
                serving = 1'b0;
            end else if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
                serving = 1'b0;
            end else if (bus.mem_req && !hang) begin
                if (!serving) begin
                    serving = 1'b1;
                    lat_cnt = int'($urandom_range(lat_hi, lat_lo));
                end
                if (lat_cnt == 0) begin
                    bus.mem_rdata = mem_rd(bus.mem_addr, bus.mem_byte);
                    if (bus.mem_we) mem_wr(bus.mem_addr, bus.mem_byte, bus.mem_wdata);
                    bus.mem_ready = 1'b1;
                end else begin
                    lat_cnt--;
                end
            end
        end
    end

    // Requester plans and expected responses
    logic [31:0] i_addr_q [$];
    int          i_gap_q  [$];
    dop_t        d_op_q   [$];
    int          d_gap_q  [$];
    bit          i_active = 1'b0;
    bit          d_active = 1'b0;
    logic [31:0] exp_i [$];
    logic [31:0] exp_d [$];
    int          owner_q [$];
    logic [31:0] last_load = '0;

    task automatic push_d(input logic we, input logic bsel, input logic [31:0] a,
                          input logic [31:0] v, input int gap);
        dop_t op;
        op.we = we; op.bsel = bsel; op.addr = a; op.wdata = v;
        d_op_q.push_back(op);
        d_gap_q.push_back(gap);
    endtask

    // Fetch requester: level request held until i_done
    initial begin
        bus.i_req  = 1'b0;
        bus.i_addr = '0;
        forever begin
            @(negedge clk);
            #1;
            if (i_active && bus.i_done) begin
                i_active = 1'b0;
                bus.i_req = 1'b0;
            end
            if (!i_active && !rst && i_addr_q.size() > 0) begin
                if (i_gap_q[0] > 0) i_gap_q[0] = i_gap_q[0] - 1;
                else begin
                    bus.i_addr = i_addr_q.pop_front();
                    void'(i_gap_q.pop_front());
                    exp_i.push_back(hang ? 32'h0 : ref_rd(bus.i_addr, 1'b0));
                    bus.i_req = 1'b1;
                    i_active  = 1'b1;
                end
            end
        end
    end

    // Data requester: program-order loads/stores
    initial begin
        dop_t op;
        logic [31:0] v;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_byte = 1'b0;
        bus.d_addr = '0; bus.d_wdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (d_active && bus.d_done) begin
                d_active = 1'b0;
                bus.d_req = 1'b0;
            end
            if (!d_active && !rst && d_op_q.size() > 0) begin
                if (d_gap_q[0] > 0) d_gap_q[0] = d_gap_q[0] - 1;
                else begin
                    op = d_op_q.pop_front();
                    void'(d_gap_q.pop_front());
                    bus.d_we = op.we; bus.d_byte = op.bsel;
                    bus.d_addr = op.addr; bus.d_wdata = op.wdata;
                    if (op.we) begin
                        if (!hang) ref_wr(op.addr, op.bsel, op.wdata);
                        exp_d.push_back(last_load);
                    end else begin
                        v = hang ? 32'h0 : ref_rd(op.addr, op.bsel);
                        last_load = v;
                        exp_d.push_back(v);
                    end
                    bus.d_req = 1'b1;
                    d_active  = 1'b1;
                end
            end
        end
    end

    // Monitor: predicted owner at each new memory request, responses checked on done
    int streak = 0;
    bit prev_mreq = 1'b0;
    always @(negedge clk) begin
        int own;
        if (rst) begin
            streak = 0;
            prev_mreq = 1'b0;
        end else begin
            if (bus.mem_req && !prev_mreq) begin
                if (bus.d_req && !(bus.i_req && streak == MAXD)) own = 1;
                else if (bus.i_req) own = 0;
                else own = 2;
                owner_q.push_back(own);
                if (bus.i_req && own == 1 && streak < MAXD) streak++;
                if (own == 0) streak = 0;
            end
            if (!bus.i_req) streak = 0;
            check("stall_if", 32'(bus.stall_if), 32'(bus.i_req & ~bus.i_done));
            check("stall_mem", 32'(bus.stall_mem), 32'(bus.d_req & ~bus.d_done));
            if (bus.i_done && bus.d_done) flag("both done high");
            if (bus.i_done) begin
                if (exp_i.size() == 0 || owner_q.size() == 0) flag("unexpected i_done");
                else begin
                    check("i_rdata", bus.i_rdata, exp_i.pop_front());
                    check("owner on i_done", 32'd0, 32'(owner_q.pop_front()));
                end
            end
            if (bus.d_done) begin
                if (exp_d.size() == 0 || owner_q.size() == 0) flag("unexpected d_done");
                else begin
                    check("d_rdata", bus.d_rdata, exp_d.pop_front());
                    check("owner on d_done", 32'd1, 32'(owner_q.pop_front()));
                end
            end
            prev_mreq = bus.mem_req;
        end
    end

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((i_addr_q.size() > 0 || d_op_q.size() > 0 || i_active || d_active || bus.mem_req)
               && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) flag("wait_idle timed out");
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_mem_req(input string name);
        int n = 0;
        while (!bus.mem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) flag(name);
    endtask

    // Single fetch with fixed one-cycle memory latency: done three cycles after request
    task automatic fetch_latency(input logic [31:0] a);
        int n = 0;
        lat_lo = 1; lat_hi = 1;
        i_addr_q.push_back(a);
        i_gap_q.push_back(0);
        while (!bus.i_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) flag("fetch never issued");
        check("fetch mem_req t+1", 32'(bus.mem_req), 32'd1);
        check("fetch mem_addr", bus.mem_addr, a);
        check("fetch mem_we c0", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        check("fetch i_done early", 32'(bus.i_done), 32'd0);
        check("fetch mem_we c1", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        check("fetch i_done t+3", 32'(bus.i_done), 32'd1);
        wait_idle(100);
    endtask

    initial begin
        int n;
        logic [9:0] seq;
        int k;
        logic [31:0] a;

        for (int i = 0; i < 512; i++) begin
            mem_b[i] = 8'($urandom);
            ref_b[i] = mem_b[i];
        end
        {mem_b[3], mem_b[2], mem_b[1], mem_b[0]} = 32'h00500093;
        {ref_b[3], ref_b[2], ref_b[1], ref_b[0]} = 32'h00500093;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset mem_req", 32'(bus.mem_req), 32'd0);
        check("reset i_done", 32'(bus.i_done), 32'd0);
        check("reset d_done", 32'(bus.d_done), 32'd0);
        check("reset err", 32'(bus.err), 32'd0);
        check("reset d_rdata", bus.d_rdata, 32'd0);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fetch only, known instruction word
        fetch_latency(32'h0);

        // Simultaneous fetch and store: data wins
        lat_lo = 0; lat_hi = 2;
        i_addr_q.push_back(32'h20); i_gap_q.push_back(0);
        push_d(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 0);
        wait_mem_req("store never issued");
        check("store mem_we", 32'(bus.mem_we), 32'd1);
        check("store mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        check("store mem_addr", bus.mem_addr, 32'h100);
        n = 0;
        while (!bus.i_done && !bus.d_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("first done is data", 32'(bus.d_done), 32'd1);
        wait_idle(200);

        // Continuous data traffic with fetch pending: 4 data grants then fetch, twice
        for (int i = 0; i < 8; i++) push_d(1'b0, 1'b0, 32'h100 + 32'(i * 4), 32'h0, 0);
        i_addr_q.push_back(32'h40); i_gap_q.push_back(0);
        i_addr_q.push_back(32'h44); i_gap_q.push_back(0);
        seq = '0; k = 0; n = 0;
        while (k < 10 && n < 400) begin
            @(negedge clk);
            n++;
            if (bus.d_done) begin seq[k] = 1'b1; k++; end
            else if (bus.i_done) begin seq[k] = 1'b0; k++; end
        end
        check("starvation done count", 32'(k), 32'd10);
        check("starvation order", 32'(seq), 32'b0111101111);
        wait_idle(200);

        // Memory never answers: timeout after TMO wait cycles, sticky err
        hang = 1'b1;
        push_d(1'b0, 1'b0, 32'h104, 32'h0, 0);
        n = 0; k = 0;
        while (!bus.d_done && k < 300) begin
            if (bus.mem_req) n++;
            @(negedge clk);
            k++;
        end
        check("timeout wait cycles", 32'(n), 32'(TMO));
        check("timeout err", 32'(bus.err), 32'd1);
        wait_idle(100);
        hang = 1'b0;
        fetch_latency(32'h4);
        check("err sticky", 32'(bus.err), 32'd1);

        // Byte load
        lat_lo = 0; lat_hi = 2;
        push_d(1'b0, 1'b1, 32'h103, 32'h0, 0);
        wait_mem_req("byte load never issued");
        check("byte mem_byte", 32'(bus.mem_byte), 32'd1);
        check("byte mem_addr", bus.mem_addr, 32'h103);
        check("byte mem_we", 32'(bus.mem_we), 32'd0);
        wait_idle(100);

        // Reset while waiting on memory, then a stray mem_ready
        hang = 1'b1;
        i_addr_q.push_back(32'h10); i_gap_q.push_back(0);
        wait_mem_req("reset-test fetch never issued");
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        bus.i_req = 1'b0; i_active = 1'b0; d_active = 1'b0; bus.d_req = 1'b0;
        i_addr_q.delete(); i_gap_q.delete(); d_op_q.delete(); d_gap_q.delete();
        exp_i.delete(); exp_d.delete(); owner_q.delete();
        last_load = '0;
        @(negedge clk);
        check("rst mem_req", 32'(bus.mem_req), 32'd0);
        check("rst err cleared", 32'(bus.err), 32'd0);
        #1 rst = 1'b0;
        #1 begin bus.mem_ready = 1'b1; bus.mem_rdata = 32'h12345678; end
        @(negedge clk);
        check("stray ready mem_req", 32'(bus.mem_req), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("no done after rst", 32'(bus.i_done | bus.d_done), 32'd0);
        end
        hang = 1'b0;
        fetch_latency(32'h8);

        // Randomized mixed traffic
        lat_lo = 0; lat_hi = 3;
        for (int i = 0; i < 80; i++) begin
            i_addr_q.push_back({24'h0, 6'($urandom_range(63, 0)), 2'b00});
            i_gap_q.push_back(int'($urandom_range(3, 0)));
            a = 32'h100 + 32'($urandom_range(255, 0));
            if ($urandom_range(1, 0) == 1) push_d(1'b0, 1'b1, a, 32'h0, int'($urandom_range(3, 0)));
            else push_d($urandom_range(1, 0) == 1, 1'b0, {a[31:2], 2'b00}, $urandom,
                        int'($urandom_range(3, 0)));
            if ($urandom_range(3, 0) == 0) push_d(1'b1, 1'b1, a, $urandom, 0);
        end
        wait_idle(6000);
        check("random exp_i drained", 32'(exp_i.size()), 32'd0);
        check("random exp_d drained", 32'(exp_d.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
